// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
//
// Debug/run sequencer for whole_cpu. Produces the CPU clock-enable so the core
// can run free, stop, single-step, or stop in front of a PC breakpoint. It also
// counts the cycles the CPU actually executed, for the bench monitor.
//
// Optional feature macro: RUN_CTRL_HALT_OP_EN
//   Defined   -> an enabled cycle whose ir equals HALT_OP returns the sequencer
//                to HALT after that cycle. The cycle is still counted.
//   Undefined -> ir and HALT_OP are ignored.
//
// Parameters
//   ADDR_W   width of pc and bp_addr
//   CNT_W    width of the executed-cycle counter
//   HALT_OP  opcode treated as HALT when the feature macro is defined
//
// Ports
//   clk       in   system clock, all state updates on posedge
//   resetBar  in   asynchronous active-low reset
//   cmd_run   in   1-cycle pulse: leave HALT and run free
//   cmd_halt  in   1-cycle pulse: stop at end of current cycle
//   cmd_step  in   1-cycle pulse: execute exactly one CPU cycle from HALT
//   bp_enable in   arms the PC breakpoint
//   bp_addr   in   breakpoint address
//   pc        in   CPU program counter (observed)
//   ir        in   CPU instruction register (observed)
//   cpu_en    out  CPU clock-enable
//   halted    out  1 while in HALT
//   bp_hit    out  sticky: the last stop was caused by the breakpoint
//   cycles    out  saturating count of posedges with cpu_en=1
// -----------------------------------------------------------------------------
module run_controller #(
  parameter int         ADDR_W  = 8,
  parameter int         CNT_W   = 16,
  parameter logic [7:0] HALT_OP = 8'h00
) (
  input  logic              clk,
  input  logic              resetBar,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic              bp_enable,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        ir,
  output logic              cpu_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   skip, skip_nxt;
  logic   bp_hit_nxt;
  logic   bp_match;
  logic   halt_op_hit;

`ifdef RUN_CTRL_HALT_OP_EN
  // A HALT opcode only matters on a cycle the CPU really executes.
  assign halt_op_hit = cpu_en & (ir == HALT_OP);
`else
  // Feature disabled: ir and HALT_OP are deliberately left without a consumer.
  logic unused_halt_op;
  assign unused_halt_op = ^{ir, HALT_OP};
  assign halt_op_hit    = 1'b0;
`endif

  // The breakpoint compares against the live pc (zero latency). skip masks
  // it for the first enabled cycle after leaving HALT so a resume from a
  // breakpoint executes the instruction at bp_addr once.
  always_comb begin
    bp_match = bp_enable & (pc == bp_addr) & ~skip;
    cpu_en   = ((state == ST_RUN) & ~bp_match) | (state == ST_STEP);
    halted   = (state == ST_HALT);
  end

  // Next-state logic. Command priority is halt > step > run. A breakpoint in
  // RUN wins over a simultaneous cmd_halt so the stop is reported as a hit.
  always_comb begin
    state_nxt  = state;
    skip_nxt   = cpu_en ? 1'b0 : skip;
    bp_hit_nxt = bp_hit;
    case (state)
      ST_HALT: begin
        if (cmd_halt) begin
          state_nxt = ST_HALT;
        end else if (cmd_step) begin
          state_nxt  = ST_STEP;
          skip_nxt   = 1'b1;
          bp_hit_nxt = 1'b0;
        end else if (cmd_run) begin
          state_nxt  = ST_RUN;
          skip_nxt   = 1'b1;
          bp_hit_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (bp_match) begin
          state_nxt  = ST_HALT;
          bp_hit_nxt = 1'b1;
        end else if (cmd_halt || halt_op_hit) begin
          state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state  <= ST_HALT;
      skip   <= 1'b0;
      bp_hit <= 1'b0;
    end else begin
      state  <= state_nxt;
      skip   <= skip_nxt;
      bp_hit <= bp_hit_nxt;
    end
  end

  // Executed-cycle counter; holds at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      cycles <= '0;
    end else if (cpu_en && (cycles != CNT_MAX)) begin
      cycles <= cycles + CNT_W'(1);
    end
  end

endmodule
